// File: rtl/axi_master_cmd_arbiter.sv
// Round-robin arbiter that shares one AXI master command port between NUM_REQ requesters,
// issuing one burst at a time and returning a per-requester completion or watchdog timeout.
module axi_master_cmd_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ-1:0]     req_write,
    input  logic [32*NUM_REQ-1:0]  req_addr,
    input  logic [32*NUM_REQ-1:0]  req_wdata,
    input  logic [8*NUM_REQ-1:0]   req_len,
    input  logic [3*NUM_REQ-1:0]   req_size,
    input  logic [2*NUM_REQ-1:0]   req_burst,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic                   rsp_error,
    output logic                   rsp_timeout,
    output logic                   start_write,
    output logic                   start_read,
    output logic [31:0]            base_write_addr,
    output logic [31:0]            base_read_addr,
    output logic [31:0]            write_data,
    output logic [7:0]             burst_len,
    output logic [2:0]             burst_size,
    output logic [1:0]             burst_type,
    input  logic                   m_done,
    input  logic                   m_error,
    output logic                   busy,
    output logic [2:0]             grant_id
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;
    localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};
    localparam logic [3:0] NR = 4'(NUM_REQ);
    localparam logic [CW-1:0] TERM = CW'(TIMEOUT_CYCLES - 1);

    logic [1:0]    state;
    logic [2:0]    last;
    logic [CW-1:0] wd_cnt;
    logic [2:0]    grant;
    logic          found;
    logic [3:0]    sum;
    logic [2:0]    cand;
    logic          handshake;
    logic          sel_write;
    logic [31:0]   sel_addr;
    logic [31:0]   sel_wdata;
    logic [7:0]    sel_len;
    logic [2:0]    sel_size;
    logic [1:0]    sel_burst;

    // Search starts just after the last owner so the most recent completer ranks lowest.
    always_comb begin
        grant = '0;
        found = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            sum = {1'b0, last} + 4'(k);
            if (sum >= NR) sum = sum - NR;
            cand = sum[2:0];
            if (!found && |(req_valid & (ONE << cand))) begin
                found = 1'b1;
                grant = cand;
            end
        end
    end

    // Ready is withheld during the response cycle so re-grant happens one cycle later.
    assign req_ready = (state == IDLE && rsp_valid == '0 && found) ? (ONE << grant) : '0;
    assign handshake = |(req_valid & req_ready);

    assign sel_write = |(req_write & (ONE << grant));
    assign sel_addr  = 32'(req_addr  >> {grant, 5'b0});
    assign sel_wdata = 32'(req_wdata >> {grant, 5'b0});
    assign sel_len   = 8'(req_len    >> {grant, 3'b0});
    assign sel_size  = 3'(req_size   >> (5'(grant) * 5'd3));
    assign sel_burst = 2'(req_burst  >> {grant, 1'b0});

    // The master bus registers double as the command latch; loading them on the
    // handshake edge puts the start pulse and stable parameters in the ISSUE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            last            <= 3'(NUM_REQ - 1);
            wd_cnt          <= '0;
            grant_id        <= '0;
            busy            <= 1'b0;
            start_write     <= 1'b0;
            start_read      <= 1'b0;
            rsp_valid       <= '0;
            rsp_error       <= 1'b0;
            rsp_timeout     <= 1'b0;
            base_write_addr <= '0;
            base_read_addr  <= '0;
            write_data      <= '0;
            burst_len       <= '0;
            burst_size      <= '0;
            burst_type      <= '0;
        end else begin
            start_write <= 1'b0;
            start_read  <= 1'b0;
            rsp_valid   <= '0;
            rsp_error   <= 1'b0;
            rsp_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (handshake) begin
                        grant_id    <= grant;
                        busy        <= 1'b1;
                        start_write <= sel_write;
                        start_read  <= !sel_write;
                        if (sel_write) base_write_addr <= sel_addr;
                        else           base_read_addr  <= sel_addr;
                        write_data  <= sel_wdata;
                        burst_len   <= sel_len;
                        burst_size  <= sel_size;
                        burst_type  <= sel_burst;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    wd_cnt <= '0;
                    state  <= WAIT;
                end
                WAIT: begin
                    if (m_done) begin
                        rsp_valid <= ONE << grant_id;
                        rsp_error <= m_error;
                        last      <= grant_id;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (wd_cnt == TERM) begin
                        rsp_valid   <= ONE << grant_id;
                        rsp_error   <= 1'b1;
                        rsp_timeout <= 1'b1;
                        last        <= grant_id;
                        state       <= DRAIN;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    // The late done of a timed-out burst is swallowed without a response.
                    if (m_done) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_master_cmd_arbiter.sv
// Directed bench for axi_master_cmd_arbiter: arbitration order, issue timing, responses,
// watchdog timeout with drain, reset during WAIT and done/timeout collision.
module tb_axi_master_cmd_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid, req_ready, req_write;
    logic [127:0] req_addr, req_wdata;
    logic [31:0]  req_len;
    logic [11:0]  req_size;
    logic [7:0]   req_burst;
    logic [3:0]   rsp_valid;
    logic         rsp_error, rsp_timeout, start_write, start_read;
    logic [31:0]  base_write_addr, base_read_addr, write_data;
    logic [7:0]   burst_len;
    logic [2:0]   burst_size;
    logic [1:0]   burst_type;
    logic         m_done, m_error, busy;
    logic [2:0]   grant_id;

    int vectors = 0;
    int miscompares = 0;

    axi_master_cmd_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
        .req_size(req_size), .req_burst(req_burst),
        .rsp_valid(rsp_valid), .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
        .start_write(start_write), .start_read(start_read),
        .base_write_addr(base_write_addr), .base_read_addr(base_read_addr),
        .write_data(write_data), .burst_len(burst_len), .burst_size(burst_size),
        .burst_type(burst_type), .m_done(m_done), .m_error(m_error),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, observed hang expected finish");
        $fatal(1, "bench time limit expired");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_cmd(input int i, input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [7:0] l, input logic [2:0] s, input logic [1:0] b);
        req_write[i]        = w;
        req_addr[i*32 +: 32]  = a;
        req_wdata[i*32 +: 32] = d;
        req_len[i*8 +: 8]     = l;
        req_size[i*3 +: 3]    = s;
        req_burst[i*2 +: 2]   = b;
    endtask

    // Waits (bounded) for a grant, checks it went to id, then completes the burst normally.
    task automatic serve(input int id);
        logic [3:0] e;
        int n;
        e = 4'(1 << id);
        n = 0;
        while (req_ready == 4'b0 && n < 10) begin
            cyc();
            n++;
        end
        chk("rr_ready", req_ready, e);
        chk("rr_never_odd", req_ready & 4'b1010, 0);
        cyc();
        chk("rr_grant_id", grant_id, id);
        chk("rr_start_read", start_read, 1);
        cyc();
        m_done = 1'b1;
        cyc();
        m_done = 1'b0;
        chk("rr_rsp_valid", rsp_valid, e);
    endtask

    initial begin
        rst = 1'b1; m_done = 1'b0; m_error = 1'b0;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        req_len = '0; req_size = '0; req_burst = '0;
        cyc(); cyc();
        chk("rst_busy", busy, 0);
        chk("rst_start", {start_write, start_read}, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_rsp", {rsp_valid, rsp_error, rsp_timeout}, 0);
        chk("rst_buses", {base_write_addr, base_read_addr}, 0);
        chk("rst_wdata", {write_data, burst_len, burst_size, burst_type}, 0);
        rst = 1'b0;
        chk("idle_no_ready", req_ready, 0);

        // Continuous 0101 requests alternate between 0 and 2.
        set_cmd(0, 1'b0, 32'h100, 32'h0, 8'd0, 3'd2, 2'd1);
        set_cmd(2, 1'b0, 32'h300, 32'h0, 8'd1, 3'd2, 2'd1);
        req_valid = 4'b0101;
        #1;
        serve(0); serve(2); serve(0); serve(2);
        req_valid = 4'b0;
        cyc();

        // Write from requester 1.
        set_cmd(1, 1'b1, 32'h1000, 32'hA0, 8'd3, 3'd2, 2'd1);
        req_valid = 4'b0010;
        #1;
        chk("wr_ready", req_ready, 4'b0010);
        cyc();
        req_valid = 4'b0;
        chk("wr_start", {start_write, start_read}, 2'b10);
        chk("wr_addr", base_write_addr, 32'h1000);
        chk("wr_data", write_data, 32'hA0);
        chk("wr_len_size_type", {burst_len, burst_size, burst_type}, {8'd3, 3'd2, 2'd1});
        chk("wr_busy_grant", {busy, grant_id}, {1'b1, 3'd1});
        cyc();
        chk("wr_start_pulse", start_write, 0);
        m_done = 1'b1;
        cyc();
        m_done = 1'b0;
        chk("wr_rsp", {rsp_valid, rsp_error, rsp_timeout}, {4'b0010, 1'b0, 1'b0});
        chk("wr_busy_done", busy, 0);
        cyc();
        chk("wr_rsp_pulse", rsp_valid, 0);

        // Read from requester 3 ending with an error.
        set_cmd(3, 1'b0, 32'h2000, 32'h0, 8'd7, 3'd2, 2'd1);
        req_valid = 4'b1000;
        #1;
        chk("rd_ready", req_ready, 4'b1000);
        cyc();
        req_valid = 4'b0;
        chk("rd_start", {start_write, start_read}, 2'b01);
        chk("rd_addr", base_read_addr, 32'h2000);
        chk("rd_wr_addr_held", base_write_addr, 32'h1000);
        cyc();
        m_done = 1'b1; m_error = 1'b1;
        cyc();
        m_done = 1'b0; m_error = 1'b0;
        chk("rd_rsp", {rsp_valid, rsp_error, rsp_timeout}, {4'b1000, 1'b1, 1'b0});
        cyc();

        // Watchdog timeout then drain.
        set_cmd(0, 1'b1, 32'h3000, 32'h55, 8'd0, 3'd2, 2'd1);
        req_valid = 4'b0001;
        #1;
        cyc();
        req_valid = 4'b0;
        cyc();
        repeat (15) cyc();
        chk("to_not_yet", rsp_valid, 0);
        cyc();
        chk("to_rsp", {rsp_valid, rsp_error, rsp_timeout}, {4'b0001, 1'b1, 1'b1});
        chk("to_busy", busy, 1);
        req_valid = 4'b0100;
        repeat (3) cyc();
        chk("drain_busy", busy, 1);
        chk("drain_no_ready", req_ready, 0);
        chk("drain_no_rsp", rsp_valid, 0);
        m_done = 1'b1;
        cyc();
        m_done = 1'b0;
        chk("drain_exit_busy", busy, 0);
        chk("drain_no_second_rsp", rsp_valid, 0);
        chk("drain_regrant", req_ready, 4'b0100);
        req_valid = 4'b0;
        cyc();

        // Reset three cycles into WAIT.
        set_cmd(1, 1'b1, 32'h4000, 32'h77, 8'd1, 3'd2, 2'd1);
        req_valid = 4'b0010;
        #1;
        cyc();
        req_valid = 4'b0;
        cyc(); cyc(); cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("mid_rst_busy_grant", {busy, grant_id}, 0);
        chk("mid_rst_buses", {base_write_addr, write_data, start_write}, 0);
        m_done = 1'b1;
        cyc();
        m_done = 1'b0;
        chk("mid_rst_no_rsp", rsp_valid, 0);
        cyc();
        chk("mid_rst_no_rsp2", rsp_valid, 0);
        set_cmd(2, 1'b1, 32'h5000, 32'h99, 8'd7, 3'd2, 2'd1);
        req_valid = 4'b0100;
        #1;
        chk("post_rst_ready", req_ready, 4'b0100);
        cyc();
        req_valid = 4'b0;
        chk("post_rst_issue", {start_write, grant_id, base_write_addr}, {1'b1, 3'd2, 32'h5000});
        cyc();
        m_done = 1'b1;
        cyc();
        m_done = 1'b0;
        chk("post_rst_rsp", rsp_valid, 4'b0100);
        cyc();

        // m_done coincides with the watchdog terminal count.
        set_cmd(0, 1'b0, 32'h6000, 32'h0, 8'd2, 3'd2, 2'd1);
        req_valid = 4'b0001;
        #1;
        cyc();
        req_valid = 4'b0;
        cyc();
        repeat (15) cyc();
        m_done = 1'b1;
        cyc();
        m_done = 1'b0;
        chk("tie_rsp", {rsp_valid, rsp_error, rsp_timeout}, {4'b0001, 1'b0, 1'b0});
        chk("tie_busy", busy, 0);
        cyc();
        req_valid = 4'b0010;
        #1;
        chk("tie_idle_busy", busy, 0);
        chk("tie_idle_ready", req_ready, 4'b0010);
        req_valid = 4'b0;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axi_master_cmd_arbiter.md
Name: axi_master_cmd_arbiter

Overview:
- Round-robin scheduler that shares one axi_master command interface between NUM_REQ requesters.
- Accepts one burst command (read or write) from a requester and issues it as a one-cycle start_write/start_read pulse with stable parameters.
- Waits for the master's done, then returns a per-requester completion with error status.
- Includes a watchdog for hung transactions.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 1024, maximum cycles in WAIT before a forced timeout response.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  reset.
- req_valid  in  NUM_REQ  per-requester command valid.
- req_ready  out  NUM_REQ  per-requester command accept.
- req_write  in  NUM_REQ  1 = write burst, 0 = read burst.
- req_addr  in  32*NUM_REQ  burst base address; slice i = bits [32i+31:32i].
- req_wdata  in  32*NUM_REQ  first write data word.
- req_len  in  8*NUM_REQ  AXI LEN (beats-1).
- req_size  in  3*NUM_REQ  AXI SIZE.
- req_burst  in  2*NUM_REQ  AXI BURST type.
- rsp_valid  out  NUM_REQ  one-cycle completion pulse to the owning requester.
- rsp_error  out  1  error qualifier, valid with any rsp_valid bit.
- rsp_timeout  out  1  timeout qualifier, valid with any rsp_valid bit.
- start_write  out  1  to master.
- start_read  out  1  to master.
- base_write_addr  out  32  to master.
- base_read_addr  out  32  to master.
- write_data  out  32  to master.
- burst_len  out  8  to master.
- burst_size  out  3  to master.
- burst_type  out  2  to master.
- m_done  in  1  master done pulse.
- m_error  in  1  master error pulse, coincident with m_done.
- busy  out  1  high in every state except IDLE.
- grant_id  out  3  index of the current owner.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. clk is the clock; rst is the reset.
- Reset values:
  - start_write, start_read, rsp_valid, rsp_error, rsp_timeout, busy = 0.
  - All master buses = 0; grant_id = 0.
  - Round-robin pointer last = NUM_REQ-1, so requester 0 has first priority.
- rst asserted in any state, including mid-WAIT, returns to IDLE with reset values next edge. The in-flight response is dropped; the master is expected to share rst.

States: IDLE, ISSUE, WAIT, DRAIN.

IDLE:
- Grant g = first i with req_valid[i], searching from last+1 upward with wrap modulo NUM_REQ.
- req_ready is combinational: req_ready[g] = 1 only in IDLE, only for the granted index; all other bits 0.
- On handshake (req_valid[g] & req_ready[g]):
  - Latch the command fields.
  - grant_id <= g; busy <= 1; go to ISSUE.
- No req_valid asserted: stay in IDLE.

ISSUE (exactly 1 cycle):
- Assert start_write if the latched write bit is 1, else start_read. Both are never high together.
- Drive base_write_addr (write) or base_read_addr (read) = latched address. The other address bus holds its previous value.
- Drive write_data, burst_len, burst_size, burst_type from the latched command.
- Next state WAIT; start_* returns to 0.
- All master buses stay stable until the next ISSUE.

WAIT:
- Watchdog counter runs, cleared on entry.
- On m_done:
  - rsp_valid[grant_id] = 1 for one cycle; rsp_error = m_error; rsp_timeout = 0.
  - last <= grant_id; go to IDLE.
- If the counter reaches TIMEOUT_CYCLES-1 with no m_done:
  - rsp_valid[grant_id] = 1, rsp_error = 1, rsp_timeout = 1.
  - last <= grant_id; go to DRAIN.
- m_done and timeout in the same cycle: m_done wins (normal response).

DRAIN:
- Hold busy = 1; no grants.
- Wait for m_done, discard it, go to IDLE.
- No second rsp_valid is produced.

Timing and ordering rules:
- Latency: handshake at cycle T; start pulse at T+1; rsp_valid in the cycle after m_done is sampled.
- Earliest re-grant: the cycle after rsp_valid.
- Requests are not queued; req_valid must be held until req_ready.
- Fairness: a requester that just completed has lowest priority at the next arbitration.
- m_done seen in IDLE or ISSUE is ignored.

Test Plan:
- Req1 write, addr 0x1000, wdata 0xA0, len 3, size 2, burst 1 → start_write pulses 1 cycle after ready. Buses carry 0x1000/0xA0/3/2/1. m_done → rsp_valid = 4'b0010, rsp_error = 0.
- req_valid = 4'b0101 held continuously → grant order 0, 2, 0, 2. Req1 and req3 never get ready.
- Req3 read, addr 0x2000; m_done together with m_error → start_read only; base_read_addr = 0x2000; rsp_valid = 4'b1000, rsp_error = 1, rsp_timeout = 0.
- TIMEOUT_CYCLES = 16, no m_done → rsp_valid with rsp_error = rsp_timeout = 1 after 16 WAIT cycles. busy stays 1 until a later m_done, which produces no response; then busy = 0.
- rst asserted 3 cycles into WAIT → next edge: IDLE, busy = 0, grant_id = 0. A subsequent m_done produces no rsp_valid. A new req2 is granted normally.
- m_done and the timeout terminal count in the same cycle → normal response, rsp_timeout = 0, next state IDLE (not DRAIN).
